// File: rtl/mod_counter.sv
// Modulo up/down counter with prescaler, synchronous clear/load and terminal-count flags.
// Optional macro COUNTER_SATURATE_EN: hold at the terminal value instead of wrapping.
module mod_counter #(
   parameter int     WIDTH    = 8,
   parameter longint MODULUS  = 256,
   parameter int     PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             wrap,
   output logic             tc
);

   localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [WIDTH-1:0] TERM    = WIDTH'(MODULUS - 64'sd1);
   localparam logic [PW-1:0]    PRE_TERM = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0]    PZERO   = {PW{1'b0}};
   localparam logic [PW-1:0]    PONE    = {{(PW-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q, count_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;
   logic             step_s;
   logic             at_term_s;

   // Next-state: clear beats load beats step; the limit is MODULUS-1, not the register width.
   always_comb begin
      count_d   = count_q;
      pre_d     = pre_q;
      tick_d    = 1'b0;
      wrap_d    = 1'b0;
      step_s    = en && (pre_q == PRE_TERM);
      at_term_s = up ? (count_q == TERM) : (count_q == ZERO);
      if (clear) begin
         count_d = ZERO;
         pre_d   = PZERO;
      end else if (load) begin
         count_d = (load_val > TERM) ? TERM : load_val;
         pre_d   = PZERO;
      end else if (step_s) begin
         pre_d = PZERO;
         if (at_term_s) begin
            wrap_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
            count_d = count_q;
            tick_d  = 1'b0;
`else
            count_d = up ? ZERO : TERM;
            tick_d  = 1'b1;
`endif
         end else begin
            count_d = up ? (count_q + ONE) : (count_q - ONE);
            tick_d  = 1'b1;
         end
      end else if (en) begin
         pre_d = pre_q + PONE;
      end else begin
         pre_d = pre_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= ZERO;
         pre_q   <= PZERO;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         pre_q   <= pre_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   assign count = count_q;
   assign tick  = tick_q;
   assign wrap  = wrap_q;
   assign tc    = up ? (count_q == TERM) : (count_q == ZERO);

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo up/down counter with programmable prescaler, synchronous load/clear and terminal-count flags. It generalises the fixed 4-bit free-running counter into a configurable building block for timers, dividers and sequencers in the lab designs. It is fully synchronous to a single clock and suitable for gate-level/SDF simulation.

## Interface
- WIDTH, 8, count register width in bits (1..32).
- MODULUS, 256, count range 0..MODULUS-1; legal 2..2^WIDTH.
- PRESCALE, 1, enabled cycles per count step; legal 1..65535; 1 means step every enabled cycle.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; gates the prescaler.
- up  input  1  direction: 1 = increment, 0 = decrement.
- clear  input  1  synchronous clear of count and prescaler.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value for load.
- count  output  WIDTH  registered count.
- tick  output  1  registered one-cycle pulse: count changed by a step.
- wrap  output  1  registered one-cycle pulse: step occurred at terminal value.
- tc  output  1  combinational: count == MODULUS-1 when up=1, count == 0 when up=0.

## Operation
- Internal prescaler pre_cnt, width clog2(PRESCALE) (min 1), range 0..PRESCALE-1.
- Step event = en && pre_cnt == PRESCALE-1. When en=1 and no step, pre_cnt increments; on step, pre_cnt returns to 0; when en=0, pre_cnt holds.
- Priority per edge: reset > clear > load > step.
- reset: count=0, pre_cnt=0, tick=0, wrap=0.
- clear: count=0, pre_cnt=0, tick=0, wrap=0.
- load: count=load_val, clamped to MODULUS-1 if load_val >= MODULUS; pre_cnt=0; tick=0, wrap=0.
- Step with up=1: count<MODULUS-1 -> count+1; count==MODULUS-1 -> 0, wrap=1.
- Step with up=0: count>0 -> count-1; count==0 -> MODULUS-1, wrap=1.
- tick=1 on every step that changes count; otherwise tick=0, wrap=0.
- Direction may change on any cycle; takes effect at the next step and does not reset pre_cnt.
- Arithmetic is modulo MODULUS, never modulo 2^WIDTH; count never leaves 0..MODULUS-1.

## Timing
- Step conditions sampled at rising edge N; new count, tick, wrap visible after edge N, held for one cycle (tick/wrap drop unless edge N+1 is also a step).
- Latency from en assertion to first step: PRESCALE edges (PRESCALE=1: first edge).
- Back-to-back steps with PRESCALE=1: tick high continuously.
- tc follows count and up combinationally, no register delay.
- Reset values: count=0, tick=0, wrap=0; tc=0 if up=1, 1 if up=0.
- Reset, clear or load asserted mid-prescale discards the partial prescale count.

## Configuration
- COUNTER_SATURATE_EN defined: no wrap-around. A step at the terminal value (MODULUS-1 going up, 0 going down) holds count, tick=0, wrap=1 for that cycle (saturation attempt flag). Direction reversal resumes normal counting.
- Not defined: wrap-around behaviour as in Operation; tick=1 on wrapping steps.

## Test plan
- WIDTH=4, MODULUS=10, PRESCALE=1, reset 1 cycle, en=1, up=1 for 12 cycles -> count 1..9,0,1,2; wrap pulses once when 9->0; tc=1 while count=9.
- Same config, up=0 from reset -> count 9,8,7...; wrap on 0->9; tc=1 at reset with count=0.
- PRESCALE=3, en=1, up=1 -> count steps every 3rd edge, tick pulses 1 cycle each step; drop en for 2 cycles mid-prescale -> step delayed exactly 2 cycles.
- load=1, load_val=7 with MODULUS=10 -> count=7 next cycle; load_val=15 -> count=9; load and clear together -> count=0.
- reset asserted while en=1 and count=5 -> count=0, tick=0, wrap=0 after the edge; counting resumes from 0, first step PRESCALE edges after reset release.
- COUNTER_SATURATE_EN, MODULUS=10, up=1 from 0 for 12 steps -> count sticks at 9, wrap=1 on each attempted step past 9, tick=0 while held; up=0 -> count 8.
